// File: rtl/mt_writeback_unit.sv
// rtl/mt_writeback_unit.sv - writeback arbiter merging ALU and load results into one register-file write port
// Optional decode bypass enabled by defining WB_BYPASS_EN.
module mt_writeback_unit #(
  parameter int NUM_THREADS  = 8,
  parameter int BITS_THREADS = $clog2(NUM_THREADS),
  parameter int DATA_WIDTH   = 32,
  parameter int LQ_DEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alu_valid,
  input  logic [BITS_THREADS-1:0] alu_tid,
  input  logic [4:0]              alu_rd,
  input  logic [DATA_WIDTH-1:0]   alu_data,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [BITS_THREADS-1:0] ld_tid,
  input  logic [4:0]              ld_rd,
  input  logic [DATA_WIDTH-1:0]   ld_data,
`ifdef WB_BYPASS_EN
  input  logic [BITS_THREADS-1:0] tid_read,
  input  logic [4:0]              a1,
  input  logic [4:0]              a2,
  input  logic [DATA_WIDTH-1:0]   rf_rd1,
  input  logic [DATA_WIDTH-1:0]   rf_rd2,
  output logic [DATA_WIDTH-1:0]   byp_rd1,
  output logic [DATA_WIDTH-1:0]   byp_rd2,
`endif
  output logic                    write_enable,
  output logic [BITS_THREADS-1:0] tid_write,
  output logic [4:0]              a3,
  output logic [DATA_WIDTH-1:0]   wd3
);

  localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [BITS_THREADS-1:0] lq_tid  [LQ_DEPTH];
  logic [4:0]              lq_rd   [LQ_DEPTH];
  logic [DATA_WIDTH-1:0]   lq_data [LQ_DEPTH];
  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;
  logic [CNT_W-1:0]        count;

  logic alu_win;
  logic ld_acc;
  logic lq_empty;
  logic head_win;
  logic ld_win;
  logic push;
  logic pop;

  // Readiness comes from the registered count only; a same-cycle pop earns no credit.
  assign ld_ready = rst_n && (count < CNT_W'(LQ_DEPTH));

  // rd==0 results are swallowed here so they never occupy the queue or the port.
  assign alu_win  = alu_valid && (alu_rd != 5'd0);
  assign ld_acc   = ld_valid && ld_ready && (ld_rd != 5'd0);
  assign lq_empty = (count == '0);
  assign head_win = !alu_win && !lq_empty;
  assign ld_win   = !alu_win && lq_empty && ld_acc;
  assign push     = ld_acc && !ld_win;
  assign pop      = head_win;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_enable <= 1'b0;
      tid_write    <= '0;
      a3           <= '0;
      wd3          <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
    end else begin
      write_enable <= alu_win || head_win || ld_win;
      if (alu_win) begin
        tid_write <= alu_tid;
        a3        <= alu_rd;
        wd3       <= alu_data;
      end else if (head_win) begin
        tid_write <= lq_tid[head];
        a3        <= lq_rd[head];
        wd3       <= lq_data[head];
      end else if (ld_win) begin
        tid_write <= ld_tid;
        a3        <= ld_rd;
        wd3       <= ld_data;
      end
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Queue storage needs no reset: push is impossible while rst_n is low.
  always_ff @(posedge clk) begin
    if (push) begin
      lq_tid[tail]  <= ld_tid;
      lq_rd[tail]   <= ld_rd;
      lq_data[tail] <= ld_data;
    end
  end

`ifdef WB_BYPASS_EN
  assign byp_rd1 = (write_enable && (tid_write == tid_read) && (a3 == a1) && (a1 != 5'd0)) ? wd3 : rf_rd1;
  assign byp_rd2 = (write_enable && (tid_write == tid_read) && (a3 == a2) && (a2 != 5'd0)) ? wd3 : rf_rd2;
`endif

endmodule

// File: tb/tb_mt_writeback_unit.sv
// tb/tb_mt_writeback_unit.sv - randomized self-checking bench for mt_writeback_unit against a queue model
module tb_mt_writeback_unit;
  localparam int BT  = 3;
  localparam int DW  = 32;
  localparam int LQD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid;
  logic [BT-1:0] alu_tid;
  logic [4:0]    alu_rd;
  logic [DW-1:0] alu_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [BT-1:0] ld_tid;
  logic [4:0]    ld_rd;
  logic [DW-1:0] ld_data;
  logic          write_enable;
  logic [BT-1:0] tid_write;
  logic [4:0]    a3;
  logic [DW-1:0] wd3;
`ifdef WB_BYPASS_EN
  logic [BT-1:0] tid_read;
  logic [4:0]    a1;
  logic [4:0]    a2;
  logic [DW-1:0] rf_rd1;
  logic [DW-1:0] rf_rd2;
  logic [DW-1:0] byp_rd1;
  logic [DW-1:0] byp_rd2;
`endif

  always #5 clk = ~clk;

  mt_writeback_unit #(.NUM_THREADS(8), .DATA_WIDTH(DW), .LQ_DEPTH(LQD)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_tid(alu_tid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_tid(ld_tid), .ld_rd(ld_rd), .ld_data(ld_data),
`ifdef WB_BYPASS_EN
    .tid_read(tid_read), .a1(a1), .a2(a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .byp_rd1(byp_rd1), .byp_rd2(byp_rd2),
`endif
    .write_enable(write_enable), .tid_write(tid_write), .a3(a3), .wd3(wd3)
  );

  typedef struct packed {
    logic [BT-1:0] tid;
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           pend[$];
  logic          e_we;
  logic [BT-1:0] e_tid;
  logic [4:0]    e_rd;
  logic [DW-1:0] e_data;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("write_enable", 64'(write_enable), 64'(e_we));
    check("tid_write", 64'(tid_write), 64'(e_tid));
    check("a3", 64'(a3), 64'(e_rd));
    check("wd3", 64'(wd3), 64'(e_data));
    check("ld_ready", 64'(ld_ready), 64'(rst_n && (pend.size() < LQD)));
`ifdef WB_BYPASS_EN
    check("byp_rd1", 64'(byp_rd1),
          64'((e_we && e_tid == tid_read && e_rd == a1 && a1 != 0) ? e_data : rf_rd1));
    check("byp_rd2", 64'(byp_rd2),
          64'((e_we && e_tid == tid_read && e_rd == a2 && a2 != 0) ? e_data : rf_rd2));
`endif
  endtask

  // Checks the current cycle, applies new inputs, and advances the model to the next edge.
  task automatic step(input logic r, input logic av, input logic [BT-1:0] at, input logic [4:0] ar,
                      input logic [DW-1:0] ad, input logic lv, input logic [BT-1:0] lt,
                      input logic [4:0] lr, input logic [DW-1:0] ldd);
    bit acc;
    wr_t w;
    @(negedge clk);
    check_outputs();
    rst_n = r; alu_valid = av; alu_tid = at; alu_rd = ar; alu_data = ad;
    ld_valid = lv; ld_tid = lt; ld_rd = lr; ld_data = ldd;
    if (!r) begin
      pend.delete();
      e_we = 0; e_tid = '0; e_rd = '0; e_data = '0;
    end else begin
      acc = lv && (pend.size() < LQD);
      if (acc && lr != 0) pend.push_back('{tid: lt, rd: lr, data: ldd});
      if (av && ar != 0) begin
        e_we = 1; e_tid = at; e_rd = ar; e_data = ad;
      end else if (pend.size() > 0) begin
        w = pend.pop_front();
        e_we = 1; e_tid = w.tid; e_rd = w.rd; e_data = w.data;
      end else begin
        e_we = 0;
      end
    end
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 0; alu_valid = 0; alu_tid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_tid = 0; ld_rd = 0; ld_data = 0;
`ifdef WB_BYPASS_EN
    tid_read = 0; a1 = 0; a2 = 0; rf_rd1 = 0; rf_rd2 = 0;
`endif
    e_we = 0; e_tid = 0; e_rd = 0; e_data = 0;
    @(posedge clk);

    // T1: reset held with both sources asserting
    for (int i = 0; i < 3; i++) step(0, 1, 3'd1, 5'd3, 32'h11, 1, 3'd2, 5'd4, 32'h22);
    idle();
    idle();

    // T2: ALU beats a simultaneous load, load follows next cycle
    step(1, 1, 3'd2, 5'd5, 32'hA5, 1, 3'd3, 5'd7, 32'h77);
    idle();
    idle();

    // T3: ALU every cycle while loads fill the queue, then drain
    for (int i = 0; i < 6; i++)
      step(1, 1, 3'(i), 5'd9, 32'h100 + i, 1, 3'(i + 1), 5'(10 + i), 32'h200 + i);
    check("t3_full", 64'(ld_ready), 64'd0);
    for (int i = 0; i < 6; i++) idle();

    // T4: writes to x0 from both sources vanish
    step(1, 1, 3'd4, 5'd0, 32'hDEAD, 1, 3'd5, 5'd0, 32'hBEEF);
    idle();
    idle();

    // T5: reset with three loads queued, then a fresh load
    for (int i = 0; i < 3; i++)
      step(1, 1, 3'd6, 5'd1, 32'h300 + i, 1, 3'd7, 5'(20 + i), 32'h400 + i);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    step(1, 0, 0, 0, 0, 1, 3'd2, 5'd12, 32'hCAFE);
    idle();
    idle();

`ifdef WB_BYPASS_EN
    // T6: forward the in-flight write to decode
    step(1, 1, 3'd1, 5'd4, 32'h1234, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    tid_read = 3'd1; a1 = 5'd4; rf_rd1 = 32'h0;
    #1;
    check("t6_bypass_hit", 64'(byp_rd1), 64'h1234);
    tid_read = 3'd0; rf_rd1 = 32'h5555;
    #1;
    check("t6_bypass_miss", 64'(byp_rd1), 64'h5555);
`endif

    for (int i = 0; i < 1500; i++) begin
      logic r;
      logic av;
      logic lv;
      r  = ($urandom_range(0, 199) != 0);
      av = ($urandom_range(0, 9) < 6);
      lv = ($urandom_range(0, 9) < 6);
`ifdef WB_BYPASS_EN
      tid_read = 3'($urandom_range(0, 7));
      a1 = 5'($urandom_range(0, 31));
      a2 = 5'($urandom_range(0, 31));
      rf_rd1 = $urandom;
      rf_rd2 = $urandom;
`endif
      step(r, av, 3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
           $urandom, lv, 3'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
    end
    for (int i = 0; i < 8; i++) idle();

    @(negedge clk);
    check_outputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
